tmp_decim: RTL and testbench
============================

Name: tmp_decim

Overview:
- Decimation and result stage downstream of the temperature-sensor sequencer.
- Receives one comparator decision per charge-balancing cycle as a strobe plus a bit.
- Discards start-up decisions, then counts ones over 2^OSR_LOG2 decisions and presents the count as a temperature code on a valid/ready output.
- Supports single-shot and continuous conversion, with abort and overrun reporting.

Parameters:
OSR_LOG2, 8, log2 of the number of decisions accumulated per result (1..12)
DISCARD, 4, number of initial decisions dropped after start (0..15)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse; begins a conversion when idle or done
abort  input  1  single-cycle pulse; returns to idle, clears accumulation
cont  input  1  1 = restart accumulation automatically after each result
sample_en  input  1  one-cycle strobe; a decision is present on sample_bit
sample_bit  input  1  decision value (1 = H branch taken)
dout  output  OSR_LOG2+1  ones count of the last completed window
out_valid  output  1  dout holds an unconsumed result
out_ready  input  1  consumer accepts dout when out_valid & out_ready
busy  output  1  high in SETTLE or ACCUM
overrun  output  1  sticky; an unconsumed result was overwritten

Behaviour:
- Reset (asynchronous): state=IDLE, dout=0, out_valid=0, overrun=0, busy=0. Internal counters are zeroed.
- States: IDLE, SETTLE, ACCUM, DONE. busy = (state==SETTLE or state==ACCUM).
- IDLE or DONE, start=1:
  - Clear the ones counter and sample counter; clear overrun.
  - Load the discard counter with DISCARD.
  - Go to SETTLE, or go straight to ACCUM when DISCARD=0.
- start while busy: ignored.
- SETTLE:
  - Each sample_en decrements the discard counter; the bit is ignored.
  - The edge that consumes the DISCARD-th strobe moves to ACCUM.
- ACCUM:
  - Each sample_en increments the sample counter and adds sample_bit to the ones counter.
  - On the edge that samples the 2^OSR_LOG2-th strobe: dout <= ones + sample_bit, out_valid <= 1, and both counters clear.
  - If cont=1 (sampled on that edge), stay in ACCUM with no re-discard; otherwise go to DONE.
- sample_en in IDLE or DONE: ignored.
- Latency: out_valid rises 1 cycle after the final strobe is presented.
- Arithmetic:
  - dout range is 0..2^OSR_LOG2 inclusive, hence OSR_LOG2+1 bits. The counter cannot wrap.
  - The sample counter is OSR_LOG2+1 bits wide.
- Output handshake:
  - out_valid&out_ready at an edge clears out_valid.
  - dout is held stable while out_valid=1 unless overwritten.
- New result while out_valid=1 and out_ready=0: dout is overwritten, out_valid stays 1, overrun <= 1.
- New result and out_ready=1 on the same edge: the new result is loaded, out_valid stays 1, overrun is unchanged.
- overrun is cleared only by reset or an accepted start.
- abort (any state):
  - Next state is IDLE and the counters clear.
  - dout, out_valid and overrun are untouched.
  - abort has priority over start and sample_en on the same edge.
- start and a final sample on the same edge in DONE: cannot occur, since DONE ignores sample_en. start is honoured.
- reset mid-conversion: everything returns to reset values immediately and asynchronously. No partial result is emitted.

Test Plan:
- OSR_LOG2=4, DISCARD=2. start; 2 strobes bit=1, then 16 strobes alternating 1,0 with 1 first -> dout=8, out_valid high 1 cycle after the 18th strobe, state DONE, busy=0.
- Same config, DISCARD=0, cont=0. 16 strobes all 1 -> dout=16 (full-scale, no wrap). Then 16 all-0 strobes after a new start -> dout=0.
- cont=1, out_ready held 0 across two windows of 16 strobes (5 ones, then 9 ones) -> after the second window dout=9, out_valid=1, overrun=1. A following start clears overrun.
- cont=1, out_ready pulsed on the exact edge the second result loads -> dout=second value, out_valid=1, overrun=0.
- abort after 7 accumulated strobes, then start plus 16 strobes with 3 ones -> dout=3. A previously held out_valid/dout is unchanged by the abort.
- Async reset asserted between clock edges mid-ACCUM -> out_valid=0, dout=0, busy=0 before the next edge. Strobes while IDLE produce no result.

Source files
------------

// File: rtl/tmp_decim.sv
// tmp_decim: decimator for the temperature-sensor comparator stream.
// It drops DISCARD start-up decisions, then counts the ones over
// 2^OSR_LOG2 decisions. The count is presented on a valid/ready output.
// Single-shot and continuous modes are supported, as are abort and a
// sticky overrun flag.
module tmp_decim #(
  parameter int OSR_LOG2 = 8,
  parameter int DISCARD  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              cont,
  input  logic              sample_en,
  input  logic              sample_bit,
  output logic [OSR_LOG2:0] dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              overrun
);

  localparam int CW = OSR_LOG2 + 1;
  // Sample count at which the current strobe completes the window.
  localparam logic [CW-1:0] LAST      = CW'((1 << OSR_LOG2) - 1);
  localparam logic [3:0]    DISC_INIT = 4'(DISCARD);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_ACCUM  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      disc_q, disc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   ones_q, ones_d;
  logic [CW-1:0]   dout_q, dout_d;
  logic            vld_q, vld_d;
  logic            ovr_q, ovr_d;
  logic [CW-1:0]   bit_ext;

  assign bit_ext   = {{OSR_LOG2{1'b0}}, sample_bit};
  assign dout      = dout_q;
  assign out_valid = vld_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q == S_SETTLE) || (state_q == S_ACCUM);

  // State and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      disc_q  <= '0;
      cnt_q   <= '0;
      ones_q  <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      disc_q  <= disc_d;
      cnt_q   <= cnt_d;
      ones_q  <= ones_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state logic.
  // The accept clears valid first, so a result loading on the same edge
  // still wins. Abort overrides everything except the output registers.
  always_comb begin
    state_d = state_q;
    disc_d  = disc_q;
    cnt_d   = cnt_q;
    ones_d  = ones_q;
    dout_d  = dout_q;
    vld_d   = vld_q;
    ovr_d   = ovr_q;

    if (vld_q && out_ready) begin
      vld_d = 1'b0;
    end

    if (abort) begin
      state_d = S_IDLE;
      disc_d  = '0;
      cnt_d   = '0;
      ones_d  = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            cnt_d   = '0;
            ones_d  = '0;
            ovr_d   = 1'b0;
            disc_d  = DISC_INIT;
            state_d = (DISCARD == 0) ? S_ACCUM : S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (sample_en) begin
            if (disc_q <= 4'd1) begin
              disc_d  = '0;
              state_d = S_ACCUM;
            end else begin
              disc_d = disc_q - 4'd1;
            end
          end
        end
        S_ACCUM: begin
          if (sample_en) begin
            if (cnt_q == LAST) begin
              dout_d = ones_q + bit_ext;
              vld_d  = 1'b1;
              if (vld_q && !out_ready) begin
                ovr_d = 1'b1;
              end
              cnt_d   = '0;
              ones_d  = '0;
              state_d = cont ? S_ACCUM : S_DONE;
            end else begin
              cnt_d  = cnt_q + 1'b1;
              ones_d = ones_q + bit_ext;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tmp_decim.sv
// Bench for tmp_decim: two instances (DISCARD=2 and DISCARD=0, both OSR_LOG2=4)
// driven from shared inputs; expectations come from ones-counting over the
// decision lists the bench itself generates.
module tb_tmp_decim;

  localparam int OSR = 4;
  localparam int N   = 1 << OSR;
  localparam int DSC = 2;

  logic clk = 1'b0;
  logic reset, start, abort, cont, sample_en, sample_bit, out_ready;
  logic [OSR:0] dout, dout0;
  logic out_valid, busy, overrun, out_valid0, busy0, overrun0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tmp_decim #(.OSR_LOG2(OSR), .DISCARD(DSC)) u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .cont(cont),
    .sample_en(sample_en), .sample_bit(sample_bit), .dout(dout),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .overrun(overrun)
  );

  tmp_decim #(.OSR_LOG2(OSR), .DISCARD(0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .cont(cont),
    .sample_en(sample_en), .sample_bit(sample_bit), .dout(dout0),
    .out_valid(out_valid0), .out_ready(out_ready), .busy(busy0), .overrun(overrun0)
  );

  // All drive tasks start and end on a falling edge.
  task automatic do_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; cont = 1'b0;
    sample_en = 1'b0; sample_bit = 1'b0; out_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1; @(negedge clk); abort = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic strobe(input logic b, input int gap, input logic rdy);
    sample_en = 1'b1; sample_bit = b; out_ready = rdy;
    @(negedge clk);
    sample_en = 1'b0; sample_bit = 1'b0; out_ready = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // n decisions with exactly k ones (random positions), or random bits if k<0.
  // The last strobe has no trailing gap; rdy_last raises out_ready with it.
  task automatic send_window(input int n, input int k, input logic rdy_last, output int ones);
    logic bits [$];
    logic t;
    int j;
    bits = {};
    for (int i = 0; i < n; i++) begin
      if (k < 0) bits.push_back(1'($urandom_range(0, 1)));
      else       bits.push_back(i < k);
    end
    for (int i = 0; i < n; i++) begin
      j = $urandom_range(0, n - 1);
      t = bits[i]; bits[i] = bits[j]; bits[j] = t;
    end
    ones = 0;
    foreach (bits[i]) ones += int'(bits[i]);
    for (int i = 0; i < n; i++) begin
      strobe(bits[i], (i == n - 1) ? 0 : $urandom_range(0, 2), (i == n - 1) ? rdy_last : 1'b0);
    end
  endtask

  task automatic send_discard();
    for (int i = 0; i < DSC; i++) strobe(1'($urandom_range(0, 1)), $urandom_range(0, 1), 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (dout !== '0)       begin failures++; $display("FAIL reset_dout got=%0d want=0", dout); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (overrun !== 1'b0)   begin failures++; $display("FAIL reset_overrun got=%b want=0", overrun); end
  endtask

  task automatic test_settle_accum();
    do_reset();
    pulse_start();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL settle_busy got=%b want=1", busy); end
    strobe(1'b1, 0, 1'b0); strobe(1'b1, 0, 1'b0);
    for (int i = 0; i < N - 1; i++) strobe(1'(i % 2 == 0), 0, 1'b0);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL settle_early_valid got=%b want=0", out_valid); end
    strobe(1'b0, 0, 1'b0);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL settle_valid got=%b want=1", out_valid); end
    checks++; if (dout !== 5'd8)      begin failures++; $display("FAIL settle_dout got=%0d want=8", dout); end
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL settle_done_busy got=%b want=0", busy); end
  endtask

  task automatic test_disc0();
    int ones;
    do_reset();
    pulse_start();
    send_window(N, N, 1'b0, ones);
    checks++; if (dout0 !== 5'(ones) || ones != N) begin failures++; $display("FAIL disc0_full got=%0d want=%0d", dout0, N); end
    checks++; if (out_valid0 !== 1'b1) begin failures++; $display("FAIL disc0_valid got=%b want=1", out_valid0); end
    consume();
    checks++; if (out_valid0 !== 1'b0) begin failures++; $display("FAIL disc0_accept got=%b want=0", out_valid0); end
    pulse_start();
    send_window(N, 0, 1'b0, ones);
    checks++; if (dout0 !== 5'd0 || out_valid0 !== 1'b1) begin failures++; $display("FAIL disc0_zero got=%0d/%b want=0/1", dout0, out_valid0); end
  endtask

  task automatic test_overrun();
    int ones;
    do_reset();
    cont = 1'b1;
    pulse_start();
    send_discard();
    send_window(N, 5, 1'b0, ones);
    checks++; if (dout !== 5'd5 || overrun !== 1'b0) begin failures++; $display("FAIL ovr_first got=%0d/%b want=5/0", dout, overrun); end
    send_window(N, 9, 1'b0, ones);
    checks++; if (dout !== 5'd9 || out_valid !== 1'b1) begin failures++; $display("FAIL ovr_second got=%0d/%b want=9/1", dout, out_valid); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b want=1", overrun); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ovr_cont_busy got=%b want=1", busy); end
    cont = 1'b0;
    pulse_abort();
    checks++; if (overrun !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL ovr_after_abort got=%b/%b want=1/0", overrun, busy); end
    pulse_start();
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_start_clear got=%b want=0", overrun); end
  endtask

  task automatic test_ready_same_edge();
    int ones;
    do_reset();
    cont = 1'b1;
    pulse_start();
    send_discard();
    send_window(N, 4, 1'b0, ones);
    send_window(N, 11, 1'b1, ones);
    checks++; if (dout !== 5'd11 || out_valid !== 1'b1) begin failures++; $display("FAIL same_edge_load got=%0d/%b want=11/1", dout, out_valid); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL same_edge_overrun got=%b want=0", overrun); end
    cont = 1'b0;
    pulse_abort();
  endtask

  task automatic test_abort();
    int ones;
    do_reset();
    pulse_start();
    send_discard();
    send_window(N, 13, 1'b0, ones);
    pulse_start();
    send_discard();
    for (int i = 0; i < 7; i++) strobe(1'b1, 0, 1'b0);
    pulse_abort();
    checks++; if (dout !== 5'd13 || out_valid !== 1'b1) begin failures++; $display("FAIL abort_hold got=%0d/%b want=13/1", dout, out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b want=0", busy); end
    consume();
    pulse_start();
    send_discard();
    send_window(N, 3, 1'b0, ones);
    checks++; if (dout !== 5'd3 || out_valid !== 1'b1) begin failures++; $display("FAIL abort_restart got=%0d/%b want=3/1", dout, out_valid); end
  endtask

  task automatic test_async_reset();
    int ones;
    do_reset();
    cont = 1'b1;
    pulse_start();
    send_discard();
    send_window(N, 6, 1'b0, ones);
    for (int i = 0; i < 5; i++) strobe(1'b1, 0, 1'b0);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || dout !== '0 || busy !== 1'b0) begin
      failures++; $display("FAIL async_reset got=%b/%0d/%b want=0/0/0", out_valid, dout, busy);
    end
    @(negedge clk);
    reset = 1'b0; cont = 1'b0;
    for (int i = 0; i < N + DSC + 2; i++) strobe(1'b1, 0, 1'b0);
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL idle_strobes got=%b/%b want=0/0", out_valid, busy); end
  endtask

  // Random single-shot conversions against a result/valid/overrun model.
  task automatic test_random();
    int ones;
    logic m_vld;
    logic exp_ovr;
    do_reset();
    m_vld = 1'b0;
    for (int it = 0; it < 10; it++) begin
      if ($urandom_range(0, 1) == 1) begin consume(); m_vld = 1'b0; end
      pulse_start();
      send_discard();
      send_window(N, -1, 1'b0, ones);
      exp_ovr = m_vld;
      m_vld = 1'b1;
      checks++; if (dout !== 5'(ones)) begin failures++; $display("FAIL rand_dout it=%0d got=%0d want=%0d", it, dout, ones); end
      checks++; if (out_valid !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL rand_state it=%0d got=%b/%b want=1/0", it, out_valid, busy); end
      checks++; if (overrun !== exp_ovr) begin failures++; $display("FAIL rand_overrun it=%0d got=%b want=%b", it, overrun, exp_ovr); end
    end
  endtask

  initial begin
    test_reset();
    test_settle_accum();
    test_disc0();
    test_overrun();
    test_ready_same_edge();
    test_abort();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
